rv32_instr_mem: RTL and testbench

- Instruction-memory responder on the fetch-side instruction bus: takes the read request and byte address, and returns the 32-bit instruction one cycle later.
- Has a byte-serial loader port with valid/ready handshake. Boot/debug logic uses it to stream a program image into the array while the core runs or stalls.
- Reports sticky misaligned and out-of-range fetch errors.

---
 rtl/rv32_instr_mem_if.sv | 37 +++
 rtl/rv32_instr_mem.sv | 134 +++++++++++++
 tb/tb_rv32_instr_mem.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_instr_mem_if.sv
// Fetch-side instruction bus plus byte-serial loader port and error reporting
// shared between the instruction memory and whoever drives it.
interface rv32_instr_mem_if;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic [31:0] instr_read_value_out;

    logic        load_start_in;
    logic        load_stop_in;
    logic [31:0] load_base_in;
    logic        load_valid_in;
    logic [7:0]  load_byte_in;
    logic        load_ready_out;
    logic        load_busy_out;
    logic [31:0] load_count_out;

    logic [1:0]  error_out;
    logic        error_clear_in;

    modport slave (
        input  instr_read_in, instr_address_in,
        output instr_read_value_out,
        input  load_start_in, load_stop_in, load_base_in, load_valid_in, load_byte_in,
        output load_ready_out, load_busy_out, load_count_out,
        output error_out,
        input  error_clear_in
    );

    modport master (
        output instr_read_in, instr_address_in,
        input  instr_read_value_out,
        output load_start_in, load_stop_in, load_base_in, load_valid_in, load_byte_in,
        input  load_ready_out, load_busy_out, load_count_out,
        input  error_out,
        output error_clear_in
    );
endinterface

// File: rtl/rv32_instr_mem.sv
// Instruction memory: one-cycle registered fetch port, sticky fetch errors,
// and a byte-serial loader that assembles little-endian words into the array.
module rv32_instr_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic               clk,
    input logic               reset_n,
    rv32_instr_mem_if.slave   bus
);
    localparam int          ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } load_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------------------------------------------------------- fetch
    logic [31:0]       fetch_off;
    logic              fetch_in_range;
    logic [ADDR_W-1:0] fetch_idx;
    logic [1:0]        new_err;
    logic [31:0]       read_value;
    logic [1:0]        err;

    assign fetch_off      = bus.instr_address_in - BASE_ADDR;
    assign fetch_in_range = (fetch_off[31:ADDR_W+2] == '0);
    assign fetch_idx      = fetch_off[ADDR_W+1:2];
    assign new_err        = {bus.instr_read_in & ~fetch_in_range,
                             bus.instr_read_in & (fetch_off[1:0] != 2'b00)};

    // NOTE: non-blocking assignment here is what gives read-before-write:
    // a same-edge write to mem is not visible to this read until the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_value <= NOP;
        end else if (bus.instr_read_in) begin
            read_value <= fetch_in_range ? mem[fetch_idx] : NOP;
        end
    end

    // A new error beats a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 2'b00;
        end else begin
            err <= (bus.error_clear_in ? 2'b00 : err) | new_err;
        end
    end

    // ---------------------------------------------------------------- loader
    load_state_t       state, state_n;
    logic [1:0]        lane, lane_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [31:0]       word, word_n;
    logic [31:0]       count, count_n;
    logic [31:0]       load_off;

    assign load_off = bus.load_base_in - BASE_ADDR;

    wire unused_ok = &{1'b0, load_off[31:ADDR_W+2], load_off[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            lane  <= 2'd0;
            ptr   <= '0;
            word  <= 32'd0;
            count <= 32'd0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            ptr   <= ptr_n;
            word  <= word_n;
            count <= count_n;
        end
    end

    // NOTE: every next-state variable is defaulted first so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        lane_n  = lane;
        ptr_n   = ptr;
        word_n  = word;
        count_n = count;

        if (bus.load_start_in) begin
            state_n = COLLECT;
            lane_n  = 2'd0;
            ptr_n   = load_off[ADDR_W+1:2];
            word_n  = 32'd0;
            count_n = 32'd0;
        end else begin
            unique case (state)
                IDLE: ;
                COLLECT: begin
                    if (bus.load_stop_in) begin
                        state_n = IDLE;
                        lane_n  = 2'd0;
                        word_n  = 32'd0;
                    end else if (bus.load_valid_in) begin
                        word_n[{lane, 3'b000} +: 8] = bus.load_byte_in;
                        lane_n                      = lane + 2'd1;
                        if (lane == 2'd3) state_n = WRITE;
                    end
                end
                WRITE: begin
                    state_n = bus.load_stop_in ? IDLE : COLLECT;
                    lane_n  = 2'd0;
                    ptr_n   = ptr + 1'b1;
                    count_n = count + 32'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it keeps its image across reset_n and
    // maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[ptr] <= word;
    end

    assign bus.instr_read_value_out = read_value;
    assign bus.error_out            = err;
    assign bus.load_ready_out       = (state == COLLECT);
    assign bus.load_busy_out        = (state != IDLE);
    assign bus.load_count_out       = count;
endmodule

// File: tb/tb_rv32_instr_mem.sv
// Directed self-checking bench for rv32_instr_mem (16-word array at base 0).
module tb_rv32_instr_mem;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic reset_n;
    int   compared;
    int   mismatched;

    rv32_instr_mem_if bus ();

    rv32_instr_mem #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.load_valid_in = 1'b1;
            bus.load_byte_in  = w[8*i +: 8];
            tick();
        end
        bus.load_valid_in = 1'b0;
    endtask

    task automatic read(input logic [31:0] a);
        bus.instr_read_in    = 1'b1;
        bus.instr_address_in = a;
        tick();
        bus.instr_read_in    = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n              = 1'b0;
        bus.instr_read_in    = 1'b1;
        bus.instr_address_in = 32'h0;
        bus.load_start_in    = 1'b0;
        bus.load_stop_in     = 1'b0;
        bus.load_base_in     = 32'h0;
        bus.load_valid_in    = 1'b0;
        bus.load_byte_in     = 8'h00;
        bus.error_clear_in   = 1'b0;

        // Reset state
        tick();
        check("rst_rdata", bus.instr_read_value_out, 32'h13);
        check("rst_err",   bus.error_out, 2'b00);
        check("rst_ready", bus.load_ready_out, 1'b0);
        check("rst_busy",  bus.load_busy_out, 1'b0);
        check("rst_count", bus.load_count_out, 32'd0);
        reset_n           = 1'b1;
        bus.instr_read_in = 1'b0;
        tick();
        check("cycle1_rdata", bus.instr_read_value_out, 32'h13);
        check("cycle1_err",   bus.error_out, 2'b00);

        // Single-word load at 0x10
        bus.load_start_in = 1'b1;
        bus.load_base_in  = 32'h10;
        tick();
        bus.load_start_in = 1'b0;
        check("ld1_ready", bus.load_ready_out, 1'b1);
        check("ld1_busy",  bus.load_busy_out, 1'b1);
        send(32'h0010_0093, 4);
        check("ld1_write_ready", bus.load_ready_out, 1'b0);
        tick();
        check("ld1_count",       bus.load_count_out, 32'd1);
        check("ld1_ready_again", bus.load_ready_out, 1'b1);
        read(32'h10);
        check("rd_0x10", bus.instr_read_value_out, 32'h0010_0093);

        // Two words starting at the last index: wraps to word 0
        bus.load_start_in = 1'b1;
        bus.load_base_in  = (DEPTH - 1) * 4;
        tick();
        bus.load_start_in = 1'b0;
        send(32'h4433_2211, 4);
        tick();
        send(32'h8877_6655, 4);
        tick();
        check("wrap_count", bus.load_count_out, 32'd2);
        read((DEPTH - 1) * 4);
        check("rd_last", bus.instr_read_value_out, 32'h4433_2211);
        read(32'h0);
        check("rd_word0", bus.instr_read_value_out, 32'h8877_6655);
        check("wrap_err", bus.error_out, 2'b00);
        bus.load_stop_in = 1'b1;
        tick();
        bus.load_stop_in = 1'b0;
        check("stop_busy", bus.load_busy_out, 1'b0);

        // Error register
        read(32'h2);
        check("mis_rdata", bus.instr_read_value_out, 32'h8877_6655);
        check("mis_err",   bus.error_out, 2'b01);
        read(DEPTH * 4);
        check("oor_rdata", bus.instr_read_value_out, 32'h13);
        check("oor_err",   bus.error_out, 2'b11);
        bus.error_clear_in = 1'b1;
        tick();
        check("clr_err", bus.error_out, 2'b00);
        read(DEPTH * 4 + 4);
        check("clr_vs_oor_err", bus.error_out, 2'b10);
        tick();
        bus.error_clear_in = 1'b0;
        check("clr2_err", bus.error_out, 2'b00);

        // Partial word then stop: no write
        bus.load_start_in = 1'b1;
        bus.load_base_in  = 32'h10;
        tick();
        bus.load_start_in = 1'b0;
        send(32'h0000_CDAB, 2);
        bus.load_stop_in = 1'b1;
        tick();
        bus.load_stop_in = 1'b0;
        check("partial_busy",  bus.load_busy_out, 1'b0);
        check("partial_ready", bus.load_ready_out, 1'b0);
        check("partial_count", bus.load_count_out, 32'd0);
        read(32'h10);
        check("partial_nowrite", bus.instr_read_value_out, 32'h0010_0093);

        // Start during WRITE: pending word still written, count restarts
        bus.load_start_in = 1'b1;
        bus.load_base_in  = 32'h14;
        tick();
        bus.load_start_in = 1'b0;
        send(32'hAAAA_AAAA, 4);
        bus.load_start_in = 1'b1;
        tick();
        bus.load_start_in = 1'b0;
        check("restart_count", bus.load_count_out, 32'd0);
        check("restart_ready", bus.load_ready_out, 1'b1);

        // Read and write word 5 at the same edge
        send(32'h5555_5555, 4);
        read(32'h14);
        check("rbw_old",   bus.instr_read_value_out, 32'hAAAA_AAAA);
        check("rbw_count", bus.load_count_out, 32'd1);
        read(32'h14);
        check("rbw_new",   bus.instr_read_value_out, 32'h5555_5555);

        // Reset mid-load: FSM idles, array intact
        send(32'h0000_1234, 2);
        #2;
        reset_n = 1'b0;
        #2;
        check("midrst_busy",  bus.load_busy_out, 1'b0);
        check("midrst_ready", bus.load_ready_out, 1'b0);
        check("midrst_count", bus.load_count_out, 32'd0);
        check("midrst_rdata", bus.instr_read_value_out, 32'h13);
        reset_n = 1'b1;
        tick();
        read(32'h14);
        check("midrst_word5", bus.instr_read_value_out, 32'h5555_5555);
        read(32'h10);
        check("midrst_word4", bus.instr_read_value_out, 32'h0010_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
